// File: rtl/sm_acc_pkg.sv
// Shared types and sign-magnitude / two's-complement helpers for the product accumulator.
// Helpers work on fixed maximal widths; callers size-cast in and slice out.
package sm_acc_pkg;

  typedef enum logic {ACCUM, DONE} state_t;

  localparam int MAX_W     = 64;
  localparam int MAX_ACC_W = 80;

  typedef struct packed {
    logic                 neg;
    logic [MAX_ACC_W-1:0] mag;
  } sm_t;

  function automatic int acc_w(input int width, input int terms);
    return width + $clog2(terms) + 1;
  endfunction

  // A set sign bit with zero magnitude negates to zero, so -0 folds to +0 naturally.
  function automatic logic signed [MAX_ACC_W-1:0] sm_to_twos(input logic neg,
                                                             input logic [MAX_W-1:0] mag);
    logic signed [MAX_ACC_W-1:0] m;
    m = MAX_ACC_W'(mag);
    return neg ? -m : m;
  endfunction

  function automatic sm_t twos_to_sm(input logic signed [MAX_ACC_W-1:0] v);
    sm_t r;
    r.neg = v[MAX_ACC_W-1];
    r.mag = r.neg ? -v : v;
    return r;
  endfunction

endpackage

// File: rtl/sm_acc_out_convert.sv
// Combinational conversion of the wide accumulator into a WIDTH-bit sign-magnitude result.
// SM_ACC_SATURATE_EN: clamp overflowing magnitudes instead of truncating them.
module sm_acc_out_convert
  import sm_acc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ACC_W = 35
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [WIDTH-1:0] out_data,
  output logic                    out_ovf
);

  sm_t              r;
  logic [WIDTH-2:0] mag_out;
  logic             sign_out;

  always_comb begin
    r       = twos_to_sm(MAX_ACC_W'(acc));
    out_ovf = |r.mag[MAX_ACC_W-1:WIDTH-1];
`ifdef SM_ACC_SATURATE_EN
    mag_out  = out_ovf ? '1 : r.mag[WIDTH-2:0];
    sign_out = r.neg;
`else
    // Truncation can wrap a negative sum to zero magnitude; never emit negative zero.
    mag_out  = r.mag[WIDTH-2:0];
    sign_out = r.neg && (mag_out != '0);
`endif
    out_data = {sign_out, mag_out};
  end

endmodule

// File: rtl/sm_product_accumulator.sv
// Sums TERMS sign-magnitude products into one sign-magnitude result over valid/ready.
// Optional build macro SM_ACC_SATURATE_EN selects saturating output conversion.
module sm_product_accumulator
  import sm_acc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TERMS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int ACC_W = acc_w(WIDTH, TERMS);
  localparam int CNT_W = $clog2(TERMS + 1);

  state_t                      state, state_nxt;
  logic                        accept, last;
  logic        [CNT_W-1:0]     count;
  logic signed [ACC_W-1:0]     acc, sum;
  logic signed [MAX_ACC_W-1:0] term_full, sum_full;
  logic        [WIDTH-1:0]     conv_data;
  logic                        conv_ovf;
  logic                        unused_sum_hi;

  assign term_full     = sm_to_twos(in_data[WIDTH-1], MAX_W'(in_data[WIDTH-2:0]));
  assign sum_full      = MAX_ACC_W'(acc) + term_full;
  assign sum           = sum_full[ACC_W-1:0];
  assign unused_sum_hi = ^sum_full[MAX_ACC_W-1:ACC_W];

  // The final term's sum is converted directly so the result registers on the accept edge.
  sm_acc_out_convert #(
    .WIDTH(WIDTH),
    .ACC_W(ACC_W)
  ) u_convert (
    .acc     (sum),
    .out_data(conv_data),
    .out_ovf (conv_ovf)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = rst;
        accept   = in_valid && rst && !clear;
        last     = accept && (count == CNT_W'(TERMS - 1));
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (clear || out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ACCUM) begin
        if (clear) begin
          acc   <= '0;
          count <= '0;
        end else if (accept) begin
          acc   <= sum;
          count <= count + 1'b1;
          if (last) begin
            out_valid <= 1'b1;
            out_data  <= conv_data;
            out_ovf   <= conv_ovf;
          end
        end
      end else if (clear || out_ready) begin
        acc       <= '0;
        count     <= '0;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sm_product_accumulator.sv
// Directed bench for sm_product_accumulator (WIDTH=32, TERMS=4), hand-computed expectations.
module tb_sm_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_ovf;

  int checks = 0;
  int failures = 0;

  sm_product_accumulator #(.WIDTH(32), .TERMS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .clear    (clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  // Presents one term and holds it until accepted; timing is relative to posedge+1.
  task automatic push(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready, out_valid, out_ovf, out_data} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%0b vld=%0b ovf=%0b data=%h required all 0",
               in_ready, out_valid, out_ovf, out_data);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%0b required=1", in_ready);
    end
  endtask

  task automatic test_basic_sum();
    out_ready = 1'b1;
    push(32'h3); push(32'h5); push(32'h80000002);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid got=%0b required=0", out_valid);
    end
    push(32'h1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h7 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL basic_sum got vld=%0b data=%h ovf=%0b required 1/00000007/0",
               out_valid, out_data, out_ovf);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_handshake_drop got=%0b required=0", out_valid);
    end
  endtask

  task automatic test_negative_zero();
    push(32'h5); push(32'h80000005); push(32'h0); push(32'h80000000);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL neg_zero got vld=%0b data=%h ovf=%0b required 1/00000000/0",
               out_valid, out_data, out_ovf);
    end
    take();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_pos, exp_neg;
`ifdef SM_ACC_SATURATE_EN
    exp_pos = 32'h7FFFFFFF; exp_neg = 32'hFFFFFFFF;
`else
    exp_pos = 32'h7FFFFFFC; exp_neg = 32'hFFFFFFFC;
`endif
    for (int i = 0; i < 4; i++) push(32'h7FFFFFFF);
    checks++;
    if (out_data !== exp_pos || out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_pos got data=%h ovf=%0b required %h/1", out_data, out_ovf, exp_pos);
    end
    take();
    for (int i = 0; i < 4; i++) push(32'hFFFFFFFF);
    checks++;
    if (out_data !== exp_neg || out_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_neg got data=%h ovf=%0b required %h/1", out_data, out_ovf, exp_neg);
    end
    take();
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    for (int i = 0; i < 4; i++) push(32'h1);
    in_valid = 1'b1;
    in_data  = 32'h9;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h4) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_hold got bad_cycles=%0d required=0 (data=%h rdy=%0b)",
               bad, out_data, in_ready);
    end
    take();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h2);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h8) begin
      failures++;
      $display("FAIL stall_fresh_sum got vld=%0b data=%h required 1/00000008", out_valid, out_data);
    end
    take();
  endtask

  task automatic test_async_reset();
    push(32'h1); push(32'h1);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_ovf, out_data} !== 35'd0) begin
      failures++;
      $display("FAIL async_reset got rdy=%0b vld=%0b ovf=%0b data=%h required all 0",
               in_ready, out_valid, out_ovf, out_data);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(32'h1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h4) begin
      failures++;
      $display("FAIL reset_fresh_sum got vld=%0b data=%h required 1/00000004", out_valid, out_data);
    end
    take();
  endtask

  task automatic test_clear();
    push(32'h2); push(32'h2); push(32'h2);
    in_valid = 1'b1; in_data = 32'h5; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h2);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_count got vld=%0b required=0 after 3 terms", out_valid);
    end
    push(32'h2);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h8) begin
      failures++;
      $display("FAIL clear_accum got vld=%0b data=%h required 1/00000008", out_valid, out_data);
    end
    take();
    for (int i = 0; i < 4; i++) push(32'h1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_done got vld=%0b required=0", out_valid);
    end
    for (int i = 0; i < 4; i++) push(32'h3);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hC) begin
      failures++;
      $display("FAIL clear_done_fresh got vld=%0b data=%h required 1/0000000c", out_valid, out_data);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_negative_zero();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached required completion");
    $fatal(1);
  end

endmodule
